// File: rtl/multicycle_ctrl_fsm_if.sv
// rtl/multicycle_ctrl_fsm_if.sv - instruction fields, memory handshake and datapath controls of the multicycle controller
interface multicycle_ctrl_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       mem_ready;
  logic       mem_req;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ALUControl;
  logic       NextPC;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic [1:0] FlagW;
  logic       illegal_op;

  modport master (
    input  Op, Funct, Rd, mem_ready,
    output mem_req, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
           NextPC, PCS, RegW, MemW, NoWrite, FlagW, illegal_op
  );

  modport slave (
    output Op, Funct, Rd, mem_ready,
    input  mem_req, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
           NextPC, PCS, RegW, MemW, NoWrite, FlagW, illegal_op
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle ARM main control FSM with memory ready handshake
// Optional performance counters (cycle_cnt, instr_cnt) under CTRL_PERF_CNT_EN.
module multicycle_ctrl_fsm (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_ctrl_fsm_if.master  bus
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]            cycle_cnt,
  output logic [31:0]            instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  state_e state_q, state_d;

  logic [3:0] cmd;
  logic [1:0] alu_dec;
  logic       nowrite_dec;
  logic       cmd_known;
  logic       cv_cmd;

  logic       mem_req, ir_write, adr_src, next_pc, pcs, reg_w, mem_w, no_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_control, flag_w;

  assign cmd = bus.Funct[4:1];

  // Data-processing command decode, used only in the ALU states
  always_comb begin
    alu_dec     = 2'b00;
    nowrite_dec = 1'b0;
    cmd_known   = 1'b1;
    cv_cmd      = 1'b0;
    case (cmd)
      4'b0100: begin alu_dec = 2'b00; cv_cmd = 1'b1; end
      4'b0010: begin alu_dec = 2'b01; cv_cmd = 1'b1; end
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      4'b1010: begin alu_dec = 2'b01; nowrite_dec = 1'b1; cv_cmd = 1'b1; end
      default: begin nowrite_dec = 1'b1; cmd_known = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = 2'b00;
    next_pc     = 1'b0;
    pcs         = 1'b0;
    reg_w       = 1'b0;
    mem_w       = 1'b0;
    no_write    = 1'b0;
    flag_w      = 2'b00;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.mem_ready;
        next_pc    = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (bus.Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_d = S_BRANCH;
          default: begin state_d = S_FETCH; illegal = 1'b1; end
        endcase
      end
      S_MEMADR: begin
        alu_src_b = 2'b01;
        state_d   = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        pcs        = (bus.Rd == 4'hF);
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        mem_w   = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        alu_src_b   = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
        alu_control = alu_dec;
        no_write    = nowrite_dec;
        // NZ on every S-form, CV only for the arithmetic commands
        flag_w      = {bus.Funct[0], bus.Funct[0] & cv_cmd};
        illegal     = ~cmd_known;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        alu_control = alu_dec;
        no_write    = nowrite_dec;
        reg_w       = 1'b1;
        pcs         = (bus.Rd == 4'hF);
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pcs        = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Side-effecting strobes stay quiet while reset is held
    if (!reset) begin
      mem_req  = 1'b0;
      ir_write = 1'b0;
      next_pc  = 1'b0;
      reg_w    = 1'b0;
      mem_w    = 1'b0;
      pcs      = 1'b0;
      flag_w   = 2'b00;
      illegal  = 1'b0;
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.IRWrite    = ir_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUControl = alu_control;
  assign bus.NextPC     = next_pc;
  assign bus.PCS        = pcs;
  assign bus.RegW       = reg_w;
  assign bus.MemW       = mem_w;
  assign bus.NoWrite    = no_write;
  assign bus.FlagW      = flag_w;
  assign bus.illegal_op = illegal;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    instr_cnt_d = instr_cnt_q;
    if ((state_q != S_FETCH) && (state_d == S_FETCH)) instr_cnt_d = instr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - directed scoreboard bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;
  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4;
  localparam int S_MEMWRITE = 5, S_EXECUTER = 6, S_EXECUTEI = 7, S_ALUWB = 8, S_BRANCH = 9;

  typedef struct packed {
    logic        mr;
    logic [18:0] exp;
  } entry_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  entry_t q[$];
  string  tags[$];

  multicycle_ctrl_fsm_if bus ();

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
  multicycle_ctrl_fsm dut (.clk(clk), .reset(reset), .bus(bus.master),
                           .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt));
`else
  multicycle_ctrl_fsm dut (.clk(clk), .reset(reset), .bus(bus.master));
`endif

  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {bus.mem_req, bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                bus.ALUControl, bus.NextPC, bus.PCS, bus.RegW, bus.MemW, bus.NoWrite,
                bus.FlagW, bus.illegal_op};

  function automatic logic [18:0] exp_vec(int st, logic [1:0] op, logic [5:0] f, logic [3:0] rd,
                                          logic mr, logic in_rst);
    logic mreq = 0, irw = 0, adr = 0, npc = 0, pcs = 0, regw = 0, memw = 0, nowr = 0, ill = 0;
    logic [1:0] srca = 0, srcb = 0, res = 0, alu = 0, flagw = 0;
    logic [3:0] cmd = f[4:1];
    logic known = 1'b1;
    logic [1:0] alu_d = 2'b00;
    logic nowr_d = 1'b0;
    case (cmd)
      4'd4:  alu_d = 2'b00;
      4'd2:  alu_d = 2'b01;
      4'd0:  alu_d = 2'b10;
      4'd12: alu_d = 2'b11;
      4'd10: begin alu_d = 2'b01; nowr_d = 1'b1; end
      default: begin alu_d = 2'b00; nowr_d = 1'b1; known = 1'b0; end
    endcase
    case (st)
      S_FETCH:    begin mreq = 1; srca = 1; srcb = 2; res = 2; irw = mr; npc = mr; end
      S_DECODE:   begin srca = 1; srcb = 2; res = 2; ill = (op == 2'b11); end
      S_MEMADR:   srcb = 1;
      S_MEMREAD:  begin mreq = 1; adr = 1; end
      S_MEMWB:    begin res = 1; regw = 1; pcs = (rd == 4'd15); end
      S_MEMWRITE: begin mreq = 1; adr = 1; memw = 1; end
      S_EXECUTER, S_EXECUTEI: begin
        srcb = (st == S_EXECUTEI) ? 2'd1 : 2'd0;
        alu = alu_d; nowr = nowr_d; ill = !known;
        flagw = {f[0], f[0] & (cmd == 4'd4 || cmd == 4'd2 || cmd == 4'd10)};
      end
      S_ALUWB:    begin alu = alu_d; nowr = nowr_d; regw = 1; pcs = (rd == 4'd15); end
      S_BRANCH:   begin srca = 2; srcb = 1; res = 2; pcs = 1; end
      default:    ;
    endcase
    if (in_rst) begin
      mreq = 0; irw = 0; npc = 0; regw = 0; memw = 0; pcs = 0; flagw = 0; ill = 0;
    end
    return {mreq, irw, adr, srca, srcb, res, alu, npc, pcs, regw, memw, nowr, flagw, ill};
  endfunction

  task automatic push(int st, logic mr, logic in_rst, string tag);
    entry_t e;
    e.mr  = mr;
    e.exp = exp_vec(st, bus.Op, bus.Funct, bus.Rd, mr, in_rst);
    q.push_back(e);
    tags.push_back(tag);
  endtask

  task automatic drain();
    entry_t e;
    string  t;
    while (q.size() > 0) begin
      e = q.pop_front();
      t = tags.pop_front();
      bus.mem_ready = e.mr;
      @(negedge clk);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", t, obs, e.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(logic [1:0] op, logic [5:0] f, logic [3:0] rd, int fw, int mw, string name);
    logic rnd;
    bus.Op = op; bus.Funct = f; bus.Rd = rd;
    for (int i = 0; i < fw; i++) push(S_FETCH, 1'b0, 1'b0, {name, "_fetchwait"});
    push(S_FETCH, 1'b1, 1'b0, {name, "_fetch"});
    rnd = 1'($urandom); push(S_DECODE, rnd, 1'b0, {name, "_decode"});
    case (op)
      2'b01: begin
        rnd = 1'($urandom); push(S_MEMADR, rnd, 1'b0, {name, "_memadr"});
        if (f[0]) begin
          for (int i = 0; i < mw; i++) push(S_MEMREAD, 1'b0, 1'b0, {name, "_memread_wait"});
          push(S_MEMREAD, 1'b1, 1'b0, {name, "_memread"});
          rnd = 1'($urandom); push(S_MEMWB, rnd, 1'b0, {name, "_memwb"});
        end else begin
          for (int i = 0; i < mw; i++) push(S_MEMWRITE, 1'b0, 1'b0, {name, "_memwrite_wait"});
          push(S_MEMWRITE, 1'b1, 1'b0, {name, "_memwrite"});
        end
      end
      2'b00: begin
        rnd = 1'($urandom); push(f[5] ? S_EXECUTEI : S_EXECUTER, rnd, 1'b0, {name, "_execute"});
        rnd = 1'($urandom); push(S_ALUWB, rnd, 1'b0, {name, "_aluwb"});
      end
      2'b10: begin
        rnd = 1'($urandom); push(S_BRANCH, rnd, 1'b0, {name, "_branch"});
      end
      default: ;
    endcase
    drain();
  endtask

  initial begin
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0;
    push(S_FETCH, 1'b1, 1'b1, "reset_init0");
    push(S_FETCH, 1'b0, 1'b1, "reset_init1");
    drain();
    reset = 1'b1;

    run_instr(2'b00, 6'b101001, 4'd3, 0, 0, "add_imm_s");
    run_instr(2'b00, 6'b001000, 4'd1, 0, 0, "add_reg");
    run_instr(2'b00, 6'b101000, 4'd5, 0, 0, "add_imm");
`ifdef CTRL_PERF_CNT_EN
    checks++;
    assert (instr_cnt === 32'd3) else begin
      errors++;
      $error("FAIL instr_cnt observed %0d expected 3", instr_cnt);
    end
    checks++;
    assert (cycle_cnt === 32'd12) else begin
      errors++;
      $error("FAIL cycle_cnt observed %0d expected 12", cycle_cnt);
    end
`endif

    run_instr(2'b01, 6'b011001, 4'd15, 0, 2, "ldr_pc");
    run_instr(2'b01, 6'b011001, 4'd2, 1, 0, "ldr_r2");
    run_instr(2'b01, 6'b011000, 4'd4, 0, 1, "str");
    run_instr(2'b00, 6'b010101, 4'd0, 0, 0, "cmp_reg");
    run_instr(2'b00, 6'b000000, 4'd6, 0, 0, "and_reg");
    run_instr(2'b00, 6'b111001, 4'd7, 2, 0, "orr_imm_s");
    run_instr(2'b00, 6'b000100, 4'd15, 0, 0, "sub_pc");
    run_instr(2'b00, 6'b001101, 4'd8, 0, 0, "bad_cmd");
    run_instr(2'b10, 6'b000000, 4'd0, 0, 0, "branch");
    run_instr(2'b11, 6'b000000, 4'd0, 0, 0, "undef_op");

    // Abandon a load while it waits on memory
    bus.Op = 2'b01; bus.Funct = 6'b011001; bus.Rd = 4'd9;
    push(S_FETCH, 1'b1, 1'b0, "abort_fetch");
    push(S_DECODE, 1'b0, 1'b0, "abort_decode");
    push(S_MEMADR, 1'b0, 1'b0, "abort_memadr");
    push(S_MEMREAD, 1'b0, 1'b0, "abort_memread");
    drain();
    reset = 1'b0;
    push(S_FETCH, 1'b1, 1'b1, "abort_reset0");
    push(S_FETCH, 1'b1, 1'b1, "abort_reset1");
    drain();
    reset = 1'b1;
    push(S_FETCH, 1'b0, 1'b0, "after_reset_fetch");
    drain();

    run_instr(2'b00, 6'b101001, 4'd3, 0, 0, "add_after_reset");
    bus.Op = 2'b00;
    push(S_FETCH, 1'b0, 1'b0, "final_fetch");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control state machine for the multicycle ARM datapath.
- Sits directly upstream of the conditional-logic stage and drives its PCS, RegW, MemW, NoWrite, FlagW and ALU-control inputs.
- The conditional-logic stage then gates these by the condition field.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, with a ready handshake on the shared instruction/data memory.

Parameters:
- None.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
Op  in  2  instruction bits [27:26]
Funct  in  6  instruction bits [25:20]; [5]=I, [4:1]=cmd, [0]=S/L
Rd  in  4  instruction bits [15:12]
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
IRWrite  out  1  load instruction register
AdrSrc  out  1  0=PC, 1=ALUOut as memory address
ALUSrcA  out  2  00=RegA, 01=PC, 10=ALUOut
ALUSrcB  out  2  00=RegB, 01=ExtImm, 10=constant 4
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
NextPC  out  1  PC write enable (unconditional)
PCS  out  1  PC-source request to conditional logic
RegW  out  1  register-write request
MemW  out  1  memory-write request
NoWrite  out  1  suppress register write (CMP)
FlagW  out  2  [1]=NZ write, [0]=CV write request
illegal_op  out  1  one-cycle pulse, undefined instruction

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH. Binary encoded; FETCH is the reset state.
- reset=0: state=FETCH asynchronously. While reset is low, mem_req, IRWrite, NextPC, RegW, MemW, PCS, FlagW and illegal_op are forced 0. Reset asserted mid-instruction abandons the instruction.
- All outputs are Moore in state except:
  - IRWrite/NextPC, which are gated by mem_ready.
  - PCS, NoWrite, FlagW and ALUControl, which are decoded from Op/Funct/Rd.
- Default value of every output is 0 unless listed for a state.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, IRWrite=NextPC=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state:
  - Op=01 -> MEMADR
  - Op=00 and Funct[5]=0 -> EXECUTER
  - Op=00 and Funct[5]=1 -> EXECUTEI
  - Op=10 -> BRANCH
  - Op=11 -> FETCH with illegal_op=1
- MEMADR: ALUSrcA=00, ALUSrcB=01, ALUControl=00. Funct[0]=1 -> MEMREAD, else MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: ResultSrc=01, RegW=1 -> FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemW=1. Hold until mem_ready=1, then FETCH.
- EXECUTER: ALUSrcA=00, ALUSrcB=00 -> ALUWB.
- EXECUTEI: ALUSrcA=00, ALUSrcB=01 -> ALUWB.
- ALUWB: ResultSrc=00, RegW=1 -> FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, PCS=1 -> FETCH.
- ALU decode applies in EXECUTER, EXECUTEI and ALUWB; ALUControl=00 elsewhere. Funct[4:1] mapping:
  - 0100 ADD -> 00
  - 0010 SUB -> 01
  - 0000 AND -> 10
  - 1100 ORR -> 11
  - 1010 CMP -> 01 with NoWrite=1
  - Any other cmd -> ALUControl=00, NoWrite=1, and illegal_op pulses in EXECUTER/EXECUTEI.
- FlagW is asserted only in EXECUTER/EXECUTEI: FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (cmd is ADD, SUB or CMP). This gives exactly one flag-write per instruction.
- PCS = Branch state, OR (RegW & Rd==4'hF) in MEMWB/ALUWB.
- Cycle counts at mem_ready=1: LDR 5, STR 4, DP 4, B 3. Each extra mem_ready=0 cycle in a memory state adds 1.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- When defined, two added outputs:
  - cycle_cnt[31:0]: increments every clock while reset=1.
  - instr_cnt[31:0]: increments on every transition into FETCH from a non-FETCH state.
- Both reset to 0 and wrap 0xFFFFFFFF -> 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset low mid-MEMREAD, then release -> state FETCH, mem_req=1 on first cycle, RegW/MemW=0 throughout reset.
- ADD with S set (Op=00, Funct=101001), mem_ready=1 -> FETCH, DECODE, EXECUTEI (FlagW=11, ALUControl=00), ALUWB (RegW=1), back to FETCH; 4 cycles.
- LDR (Op=01, Funct[0]=1) with mem_ready low 2 cycles in MEMREAD -> 7 cycles; MEMWB ResultSrc=01; PCS=1 only if Rd=15.
- STR (Funct[0]=0) -> MEMWRITE asserts MemW=1, mem_req=1, AdrSrc=1 until mem_ready; RegW never 1.
- CMP register (Funct=010101) -> EXECUTER FlagW=11, ALUControl=01; ALUWB RegW=1, NoWrite=1.
- Op=11 in DECODE -> illegal_op=1 for exactly one cycle, next state FETCH. Under CTRL_PERF_CNT_EN, after 3 ADDs from reset, instr_cnt=3 and cycle_cnt=12.
